game_timer: RTL and testbench
=============================

# game_timer

Elapsed/remaining game-time generator clocked by the VGA frame clock. It counts frames into seconds and produces the three BCD digits M:SS, which the color mapper renders as the on-screen timer. The color mapper treats digit index 2 as minutes, index 1 as tens of seconds and index 0 as ones of seconds. The block sits directly upstream of the color mapper, and its game_clock output wires straight into that block's gameClock input.

## Interface
Parameters:
- FRAMES_PER_SEC, default 60: frame_clk edges per timer second. Must be ≥ 2.
- FC_W, default $clog2(FRAMES_PER_SEC): width of the internal frame counter.

Ports:
- frame_clk  in  1  frame clock, one rising edge per VGA frame.
- reset  in  1  reset, synchronous, active-high, clock frame_clk.
- start  in  1  one-cycle pulse; (re)loads the digits and begins counting.
- stop  in  1  one-cycle pulse; halts counting and returns to IDLE; digits hold.
- pause  in  1  level; while 1 in RUN, counting is frozen.
- count_down  in  1  level, sampled only on the start cycle; 1 = countdown from preset, 0 = count up from 0:00.
- preset  in  4 x [3]  preset digits (index 2 = minutes, 1 = tens of seconds, 0 = ones of seconds).
- game_clock  out  4 x [3]  registered BCD digits, M:SS; connects to the color mapper's gameClock.
- sec_tick  out  1  registered one-cycle pulse, high in the cycle the digits show a new value.
- running  out  1  registered; 1 in RUN only.
- expired  out  1  registered; 1 in DONE only.

## Operation
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Reset: state = IDLE; game_clock = 0:00 (all digits 0); frame_cnt = 0; sec_tick = running = expired = 0.
- Command priority within one cycle: reset > stop > start > pause.
- stop in any state: go to IDLE, digits hold, frame_cnt = 0, expired = 0.
- start in any state (restart is allowed), loading the digits as follows:
  - count_down = 0: digits = 0:00, mode = up.
  - count_down = 1: digits = preset after clamping: minutes > 9 becomes 9; tens of seconds > 5 becomes 5; ones of seconds > 9 becomes 9. Mode = down.
  - In both cases frame_cnt = 0 and next state = RUN.
  - Exception: count_down = 1 with clamped preset = 0:00 goes straight to DONE; expired = 1 on the next cycle.
- RUN with pause = 1: go to PAUSE; frame_cnt does not advance that cycle.
- RUN with pause = 0: frame_cnt += 1. When frame_cnt == FRAMES_PER_SEC-1:
  - frame_cnt = 0, digits step one second, sec_tick = 1.
  - Up mode: ones 9→0 carries into tens; tens 5→0 carries into minutes.
  - Down mode: ones 0→9 borrows from tens; tens 0→5 borrows from minutes.
- Terminal count:
  - Up mode at 9:59 with a pending step: digits stay 9:59, sec_tick = 0, go to DONE.
  - Down mode step that produces 0:00: digits = 0:00, sec_tick = 1, go to DONE.
- PAUSE: digits and frame_cnt hold. pause = 0 returns to RUN on the next edge.
- DONE: digits hold; expired = 1. Only start, stop or reset leave DONE.
- Digits never leave BCD range: minutes 0–9, tens of seconds 0–5, ones of seconds 0–9.

## Timing
- Start latency: start sampled at edge N → state = RUN, digits loaded and running = 1 after edge N.
- First second step: occurs at edge N + FRAMES_PER_SEC; sec_tick is high for the cycle following that edge.
- Seconds then step every FRAMES_PER_SEC edges while in RUN.
- Pause accounting: frames spent in PAUSE, including the edge on which PAUSE is entered, are not counted. Partial-second progress (frame_cnt) is preserved across a pause.
- expired and running change on the same edge as the state change into or out of DONE/RUN.
- Reset asserted mid-count: takes effect on the next edge; all outputs return to their reset values; pending start, stop and pause are ignored that cycle.
- Simultaneous events:
  - start with pause = 1: enter RUN, then PAUSE on the following edge if pause is still 1.
  - stop with start: stop wins.

## Test plan
- Reset, then start with count_down = 0 → running = 1, digits 0:00. After 60 edges: digits 0:01, one sec_tick. After 600 edges from start: digits 0:10.
- Up count across minute and saturation: count up to 0:59, then one more second → 1:00. Run to 9:59 → after 60 further edges digits stay 9:59, expired = 1, running = 0, no sec_tick.
- Countdown: preset 1:00, count_down = 1, start → after 60 edges 0:59. Preset 0:01 → after 60 edges digits 0:00, sec_tick = 1, expired = 1. Preset 0:00 → expired = 1 one edge after start.
- Clamping: preset {minutes = 12, tens = 7, ones = 15} with count_down = 1 → loaded digits 9:59.
- Pause and stop: pause = 1 for 100 edges in mid-second (frame_cnt = 30) → digits and frame_cnt unchanged. Release → next step after 30 more edges. stop → IDLE, digits hold, running = 0.
- Priority and reset: stop and start in the same cycle → IDLE. Reset during RUN at 3:27 → digits 0:00, all flags 0 next edge.

Source files
------------

// File: rtl/game_timer.sv
// Frame-clocked M:SS game timer: counts frames into seconds, either up from 0:00
// or down from a clamped preset, and drives the BCD digits shown by the color mapper.
module game_timer #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int FC_W           = $clog2(FRAMES_PER_SEC)
) (
    input  logic            frame_clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            pause,
    input  logic            count_down,
    input  logic [2:0][3:0] preset,
    output logic [2:0][3:0] game_clock,
    output logic            sec_tick,
    output logic            running,
    output logic            expired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0][3:0] MAX_TIME  = 12'h959;
    localparam logic [2:0][3:0] ZERO_TIME = 12'h000;
    localparam logic [FC_W-1:0] LAST_FRAME = FC_W'(FRAMES_PER_SEC - 1);

    state_t          state, state_nxt;
    logic            mode_down, mode_down_nxt;
    logic [FC_W-1:0] frame_cnt, frame_cnt_nxt;
    logic [2:0][3:0] digits_nxt;
    logic            sec_tick_nxt;
    logic            running_nxt;
    logic            expired_nxt;

    logic [2:0][3:0] preset_clamped;
    logic [2:0][3:0] digits_up;
    logic [2:0][3:0] digits_down;
    logic            last_frame;
    logic            at_max;

    // Out-of-range preset digits saturate to the largest legal BCD value.
    function automatic logic [2:0][3:0] clamp_preset(input logic [2:0][3:0] p);
        logic [2:0][3:0] r;
        r[2] = (p[2] > 4'd9) ? 4'd9 : p[2];
        r[1] = (p[1] > 4'd5) ? 4'd5 : p[1];
        r[0] = (p[0] > 4'd9) ? 4'd9 : p[0];
        return r;
    endfunction

    function automatic logic [2:0][3:0] step_up(input logic [2:0][3:0] d);
        logic [2:0][3:0] r;
        r = d;
        if (d[0] == 4'd9) begin
            r[0] = 4'd0;
            if (d[1] == 4'd5) begin
                r[1] = 4'd0;
                r[2] = d[2] + 4'd1;
            end else begin
                r[1] = d[1] + 4'd1;
            end
        end else begin
            r[0] = d[0] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [2:0][3:0] step_down(input logic [2:0][3:0] d);
        logic [2:0][3:0] r;
        r = d;
        if (d[0] == 4'd0) begin
            r[0] = 4'd9;
            if (d[1] == 4'd0) begin
                r[1] = 4'd5;
                r[2] = d[2] - 4'd1;
            end else begin
                r[1] = d[1] - 4'd1;
            end
        end else begin
            r[0] = d[0] - 4'd1;
        end
        return r;
    endfunction

    assign preset_clamped = clamp_preset(preset);
    assign digits_up      = step_up(game_clock);
    assign digits_down    = step_down(game_clock);
    assign last_frame     = (frame_cnt == LAST_FRAME);
    assign at_max         = (game_clock == MAX_TIME);

    // State register; reset is synchronous and clears every output.
    always_ff @(posedge frame_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= IDLE;
            mode_down  <= 1'b0;
            frame_cnt  <= '0;
            game_clock <= ZERO_TIME;
            sec_tick   <= 1'b0;
            running    <= 1'b0;
            expired    <= 1'b0;
        end else begin
            state      <= state_nxt;
            mode_down  <= mode_down_nxt;
            frame_cnt  <= frame_cnt_nxt;
            game_clock <= digits_nxt;
            sec_tick   <= sec_tick_nxt;
            running    <= running_nxt;
            expired    <= expired_nxt;
        end
    end

    // Next state and datapath; stop outranks start, start outranks pause.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_nxt     = state;
        mode_down_nxt = mode_down;
        frame_cnt_nxt = frame_cnt;
        digits_nxt    = game_clock;
        sec_tick_nxt  = 1'b0;

        if (stop) begin
            state_nxt     = IDLE;
            frame_cnt_nxt = '0;
        end else if (start) begin
            frame_cnt_nxt = '0;
            mode_down_nxt = count_down;
            if (count_down) begin
                digits_nxt = preset_clamped;
                state_nxt  = (preset_clamped == ZERO_TIME) ? DONE : RUN;
            end else begin
                digits_nxt = ZERO_TIME;
                state_nxt  = RUN;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSE;
                    end else if (!last_frame) begin
                        frame_cnt_nxt = frame_cnt + FC_W'(1);
                    end else begin
                        frame_cnt_nxt = '0;
                        if (!mode_down) begin
                            // Saturate at 9:59 instead of wrapping.
                            if (at_max) begin
                                state_nxt = DONE;
                            end else begin
                                digits_nxt   = digits_up;
                                sec_tick_nxt = 1'b1;
                            end
                        end else begin
                            digits_nxt   = digits_down;
                            sec_tick_nxt = 1'b1;
                            if (digits_down == ZERO_TIME) begin
                                state_nxt = DONE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_nxt = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags follow the state being entered so they register with it.
    always_comb begin
        running_nxt = (state_nxt == RUN);
        expired_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer at 60 frames per second; expected digits are
// hand-derived from frame counts since the last start/step.
module tb_game_timer;

    logic            frame_clk;
    logic            reset;
    logic            start;
    logic            stop;
    logic            pause;
    logic            count_down;
    logic [2:0][3:0] preset;
    logic [2:0][3:0] game_clock;
    logic            sec_tick;
    logic            running;
    logic            expired;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_cnt = 0;

    game_timer #(.FRAMES_PER_SEC(60)) dut (
        .frame_clk  (frame_clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .count_down (count_down),
        .preset     (preset),
        .game_clock (game_clock),
        .sec_tick   (sec_tick),
        .running    (running),
        .expired    (expired)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time got exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, sampling 1 time unit after each; counts sec_tick pulses.
    task automatic run_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge frame_clk);
            #1;
            if (sec_tick) tick_cnt++;
        end
    endtask

    task automatic do_start(input logic cd, input logic [11:0] p);
        count_down = cd;
        preset     = p;
        start      = 1'b1;
        run_edges(1);
        start      = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        run_edges(1);
        stop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        count_down = 1'b0; preset = 12'h000;
        run_edges(2);
        check("rst_digits",  32'(game_clock), 32'h000);
        check("rst_tick",    32'(sec_tick),   32'h0);
        check("rst_running", 32'(running),    32'h0);
        check("rst_expired", 32'(expired),    32'h0);
        reset = 1'b0;
        run_edges(3);
        check("idle_running", 32'(running), 32'h0);

        // Count up from 0:00
        do_start(1'b0, 12'h000);
        check("up_running", 32'(running),    32'h1);
        check("up_load",    32'(game_clock), 32'h000);
        tick_cnt = 0;
        run_edges(59);
        check("up_59_digits", 32'(game_clock), 32'h000);
        check("up_59_ticks",  32'(tick_cnt),   32'd0);
        run_edges(1);
        check("up_60_digits", 32'(game_clock), 32'h001);
        check("up_60_tick",   32'(sec_tick),   32'h1);
        run_edges(1);
        check("tick_one_cycle", 32'(sec_tick), 32'h0);
        run_edges(539);
        check("up_600_digits", 32'(game_clock), 32'h010);
        check("up_600_ticks",  32'(tick_cnt),   32'd10);

        // Minute carry and saturation at 9:59
        run_edges(2940);
        check("up_059", 32'(game_clock), 32'h059);
        run_edges(60);
        check("up_100", 32'(game_clock), 32'h100);
        run_edges(32340);
        check("up_959", 32'(game_clock), 32'h959);
        check("up_959_running", 32'(running), 32'h1);
        tick_cnt = 0;
        run_edges(60);
        check("sat_digits",  32'(game_clock), 32'h959);
        check("sat_expired", 32'(expired),    32'h1);
        check("sat_running", 32'(running),    32'h0);
        check("sat_ticks",   32'(tick_cnt),   32'd0);
        pause = 1'b1;
        run_edges(70);
        pause = 1'b0;
        check("done_hold_digits",  32'(game_clock), 32'h959);
        check("done_hold_expired", 32'(expired),    32'h1);

        // Countdown from 1:00
        do_start(1'b1, 12'h100);
        check("dn_load",    32'(game_clock), 32'h100);
        check("dn_expired", 32'(expired),    32'h0);
        run_edges(60);
        check("dn_059", 32'(game_clock), 32'h059);

        // Countdown 0:01 to zero (restart while running)
        do_start(1'b1, 12'h001);
        check("dn1_load", 32'(game_clock), 32'h001);
        run_edges(59);
        check("dn1_59_expired", 32'(expired), 32'h0);
        run_edges(1);
        check("dn1_zero",    32'(game_clock), 32'h000);
        check("dn1_tick",    32'(sec_tick),   32'h1);
        check("dn1_expired", 32'(expired),    32'h1);
        check("dn1_running", 32'(running),    32'h0);

        // Countdown from 0:00 expires immediately
        do_stop();
        check("stop_clears_expired", 32'(expired), 32'h0);
        do_start(1'b1, 12'h000);
        check("dn0_expired", 32'(expired), 32'h1);
        check("dn0_running", 32'(running), 32'h0);
        check("dn0_tick",    32'(sec_tick), 32'h0);

        // Clamping
        do_start(1'b1, 12'hC7F);
        check("clamp_load", 32'(game_clock), 32'h959);
        run_edges(60);
        check("clamp_step", 32'(game_clock), 32'h958);

        // Pause in mid-second preserves frame progress
        do_start(1'b0, 12'h000);
        run_edges(30);
        pause = 1'b1;
        tick_cnt = 0;
        run_edges(100);
        check("pause_digits",  32'(game_clock), 32'h000);
        check("pause_running", 32'(running),    32'h0);
        check("pause_ticks",   32'(tick_cnt),   32'd0);
        pause = 1'b0;
        run_edges(1);
        check("resume_running", 32'(running), 32'h1);
        run_edges(29);
        check("resume_29", 32'(game_clock), 32'h000);
        run_edges(1);
        check("resume_30", 32'(game_clock), 32'h001);
        check("resume_tick", 32'(sec_tick), 32'h1);

        // Stop holds digits
        do_stop();
        check("stop_running", 32'(running),    32'h0);
        check("stop_digits",  32'(game_clock), 32'h001);
        run_edges(100);
        check("stop_hold", 32'(game_clock), 32'h001);

        // stop beats start
        stop = 1'b1;
        do_start(1'b0, 12'h000);
        stop = 1'b0;
        check("prio_running", 32'(running),    32'h0);
        check("prio_digits",  32'(game_clock), 32'h001);

        // start with pause held: RUN, then PAUSE
        pause = 1'b1;
        do_start(1'b1, 12'h327);
        check("sp_running1", 32'(running), 32'h1);
        run_edges(1);
        check("sp_running2", 32'(running), 32'h0);
        pause = 1'b0;
        run_edges(1);
        check("sp_resume", 32'(running), 32'h1);

        // Reset mid-count at 3:27 overrides a pending start
        run_edges(10);
        check("pre_rst_digits", 32'(game_clock), 32'h327);
        reset = 1'b1;
        start = 1'b1;
        run_edges(1);
        reset = 1'b0;
        start = 1'b0;
        check("mid_rst_digits",  32'(game_clock), 32'h000);
        check("mid_rst_running", 32'(running),    32'h0);
        check("mid_rst_expired", 32'(expired),    32'h0);
        check("mid_rst_tick",    32'(sec_tick),   32'h0);
        run_edges(5);
        check("post_rst_idle", 32'(running), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
